// File: rtl/rot_pkg.sv
// ============================================================================
// Module   : rot_pkg
// Brief    : Shared types and constants for the rotate sequencer slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rot_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int AMT_W_DEF = $clog2(WIDTH_DEF);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    HOLD   = 2'd2
  } state_t;

endpackage : rot_pkg

`default_nettype wire

// File: rtl/rotate_step.sv
// ============================================================================
// Module   : rotate_step
// Brief    : Combinational single-position rotator (left or right).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_step
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;

  assign w_left  = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
  assign w_right = {data_i[0], data_i[WIDTH-1:1]};
  assign data_o  = (dir_i == DIR_RIGHT) ? w_right : w_left;

endmodule : rotate_step

`default_nettype wire

// File: rtl/rotate_sequencer.sv
// ============================================================================
// Module   : rotate_sequencer
// Brief    : Valid/ready command front-end rotating a word one bit per clock.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rotate_sequencer
  import rot_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [AMT_W-1:0] r_cnt;
  logic             r_dir;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_data_nxt;
  logic [AMT_W-1:0] w_cnt_nxt;
  logic             w_dir_nxt;
  logic [WIDTH-1:0] w_step;
  logic             w_accept;

  rotate_step #(
    .WIDTH (WIDTH)
  ) u_rotate_step (
    .data_i (r_data),
    .dir_i  (r_dir),
    .data_o (w_step)
  );

  // Ready comes from registered state only; gated so nothing is taken in reset.
  assign in_ready  = reset && ((r_state == IDLE) || ((r_state == HOLD) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == HOLD);
  assign out_data  = r_data;
  assign busy      = (r_state != IDLE);

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_data_nxt  = in_data;
          w_cnt_nxt   = in_amount;
          w_dir_nxt   = in_dir;
          w_state_nxt = (in_amount != '0) ? ROTATE : HOLD;
        end
      end

      ROTATE: begin
        w_data_nxt = w_step;
        w_cnt_nxt  = r_cnt - AMT_W'(1);
        if (r_cnt == AMT_W'(1)) begin
          w_state_nxt = HOLD;
        end
      end

      HOLD: begin
        // A new command may ride in on the same edge the result leaves.
        if (w_accept) begin
          w_data_nxt  = in_data;
          w_cnt_nxt   = in_amount;
          w_dir_nxt   = in_dir;
          w_state_nxt = (in_amount != '0) ? ROTATE : HOLD;
        end else if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_cnt   <= '0;
      r_dir   <= DIR_LEFT;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

endmodule : rotate_sequencer

`default_nettype wire

// File: tb/tb_rotate_sequencer.sv
// ============================================================================
// Module   : tb_rotate_sequencer
// Brief    : Scoreboard bench for rotate_sequencer with a reference rotate model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rotate_sequencer;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [AW-1:0] in_amount;
  logic          in_dir;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          busy;

  logic rand_bp;
  logic ready_force;
  logic bp_bit;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  bit   seen;

  assign out_ready = rand_bp ? bp_bit : ready_force;

  rotate_sequencer #(
    .WIDTH (W),
    .AMT_W (AW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amount (in_amount),
    .in_dir    (in_dir),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial bp_bit = 1'b1;
  always @(posedge clk) begin
    #1 bp_bit = ($urandom_range(0, 3) != 0);
  end

  // Rotation as a whole-word operation on a doubled copy of the data.
  function automatic logic [W-1:0] rot_ref(input logic [W-1:0] d, input int n, input logic dir);
    logic [2*W-1:0] dd;
    logic [2*W-1:0] t;
    dd = {d, d};
    if (dir == 1'b0) begin
      t = dd << n;
      return t[2*W-1:W];
    end
    t = dd >> n;
    return t[W-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor pops on every output transfer; acceptance watcher pushes the model result.
  always @(negedge clk) begin
    if (!reset) begin
      sb.delete();
      seen = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", out_data);
        end else begin
          if (!seen) begin
            chk("latency", cyc, sb[0].due);
            seen = 1'b1;
          end
          if (out_ready) begin
            chk("out_data", out_data, sb[0].data);
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.data = rot_ref(in_data, int'(in_amount), in_dir);
        e.due  = cyc + 1 + int'(in_amount);
        sb.push_back(e);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input int n, input logic dir);
    bit ok;
    ok        = 1'b0;
    in_valid  = 1'b1;
    in_data   = d;
    in_amount = AW'(n);
    in_dir    = dir;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready never rose for data 0x%0h", d);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_amount   = '0;
    in_dir      = 1'b0;
    rand_bp     = 1'b0;
    ready_force = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_in_ready", in_ready, 1);

    // Single left step wraps the MSB.
    send(8'h81, 1, 1'b0);
    drain();
    chk("t1_busy", busy, 0);
    chk("t1_out_valid", out_valid, 0);

    // Three right steps; ready stays low while rotating.
    send(8'hB4, 3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_in_ready_rot", in_ready, 0);
      chk("t2_busy", busy, 1);
    end
    drain();

    // Back-to-back zero-amount commands, one per cycle.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data   = 8'h5A + 8'(i);
      in_amount = '0;
      in_dir    = 1'(i);
      @(negedge clk);
      chk("t3_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();

    // Held result under backpressure with a second command waiting.
    ready_force = 1'b0;
    send(8'h01, 7, 1'b0);
    in_valid  = 1'b1;
    in_data   = 8'h3C;
    in_amount = AW'(2);
    in_dir    = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("t4_in_ready_held", in_ready, 0);
      if (i >= 7) begin
        chk("t4_out_valid", out_valid, 1);
        chk("t4_out_data_held", out_data, 8'h80);
      end
    end
    @(posedge clk);
    #1 ready_force = 1'b1;
    @(negedge clk);
    chk("t4_in_ready_release", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    drain();

    // Asynchronous reset mid-rotation discards everything.
    send(8'hC3, 5, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_busy", busy, 0);
    chk("t5_in_ready", in_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_no_replay", out_valid, 0);
    @(posedge clk);
    #1;
    send(8'h0F, 4, 1'b1);
    drain();

    // Randomized traffic with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(W'($urandom), int'($urandom_range(0, W - 1)), 1'($urandom));
    end
    rand_bp     = 1'b0;
    ready_force = 1'b1;
    drain();
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule : tb_rotate_sequencer

`default_nettype wire

// File: doc/rotate_sequencer.md
Name: rotate_sequencer

Overview:
- Command front-end for the rotate datapath.
- Accepts a byte plus a rotate amount and direction over a valid/ready handshake.
- Performs the rotation one bit position per clock, using the same single-step rotate semantics as the downstream rotate stage.
- Presents the result on a valid/ready output held stable under backpressure; sits directly upstream of, and feeds, the rotate/output stage.

Parameters:
- WIDTH, 8, data width in bits; must be a power of two, at least 2.
- AMT_W, $clog2(WIDTH) = 3, width of the rotate-amount field and of the step counter.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; the only reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command accepted when in_valid && in_ready at a rising edge.
- in_data  input  WIDTH  byte to rotate.
- in_amount  input  AMT_W  number of single-position rotate steps, 0..WIDTH-1.
- in_dir  input  1  0 = rotate left (MSB wraps to LSB); 1 = rotate right (LSB wraps to MSB).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer ready; transfer when out_valid && out_ready.
- out_data  output  WIDTH  rotated result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; out_valid = 0; out_data = 0; step counter = 0; busy = 0.
  - in_ready is forced 0 while reset is low.
  - Any rotation in progress or result held is discarded; nothing is replayed after reset.
- FSM states: IDLE, ROTATE, HOLD.
- in_ready = (state == IDLE) || (state == HOLD && out_ready). Registered-state decode only; no dependency on in_valid.
- Acceptance (cycle c):
  - Captures in_data into the data register, in_amount into the counter, in_dir into the direction register.
  - Next state is ROTATE if in_amount != 0, otherwise HOLD.
- ROTATE:
  - Each cycle, data register <= single-step rotate of itself in the captured direction; counter decrements by 1.
  - When the counter equals 1 in a cycle, that step is the last; next state = HOLD.
  - in_ready = 0 and out_valid = 0 throughout ROTATE.
- Latency: for amount N, out_valid is first high in cycle c+1+N (N=0 gives c+1). No throughput penalty beyond this.
- HOLD:
  - out_valid = 1; out_data = data register.
  - out_data and out_valid are held stable while out_ready = 0.
  - On out_ready = 1 without a new acceptance: next state = IDLE, out_valid deasserts next cycle.
  - Simultaneous out_ready and in_valid in HOLD: the output transfer completes and the new command is accepted in the same cycle. Next state follows the new amount: ROTATE, or HOLD again with the new data for amount 0. No bubble for amount 0.
- in_dir and in_amount are sampled only at acceptance; changes while busy are ignored.
- Counter arithmetic is unsigned AMT_W-bit. It never wraps, because ROTATE is left at count 1.
- busy = (state != IDLE); it is high in HOLD too.
- Rotate amount WIDTH-1 left is equivalent to 1 right. No short-circuit: always exactly N steps.
- Amount 0 passes in_data unchanged.

Decomposition:
- Package rot_pkg holds:
  - the FSM state enum (IDLE, ROTATE, HOLD);
  - constants DIR_LEFT = 1'b0 and DIR_RIGHT = 1'b1;
  - defaults for WIDTH and AMT_W.
- Sub-module rotate_step: purely combinational single-position rotator.
  - Ports: data_i[WIDTH], dir_i, data_o[WIDTH].
  - Left result {data[WIDTH-2:0], data[WIDTH-1]}; right result {data[0], data[WIDTH-1:1]}.
  - Instantiated once in the top-level feedback path.

Test Plan:
1. Accept in_data=8'h81, amount=1, dir=0 in cycle c, out_ready=1 -> out_valid high in cycle c+2, out_data=8'h03; then IDLE, busy=0.
2. in_data=8'hB4, amount=3, dir=1 -> out_data=8'h96 with out_valid first high in cycle c+4; in_ready=0 during cycles c+1..c+3.
3. in_data=8'h5A, amount=0 -> out_data=8'h5A, out_valid in cycle c+1. Back-to-back amount-0 commands with out_ready=1 -> one result per cycle, no bubbles.
4. in_data=8'h01, amount=7, dir=0, out_ready=0 for 5 cycles with a second command pending on in_valid:
   - out_data=8'h80 held stable; in_ready=0 throughout.
   - Raise out_ready -> 8'h80 transfers and the second command is accepted in the same cycle.
5. Drive reset low during ROTATE, mid-count, of amount=5 -> out_valid=0, out_data=0, busy=0 immediately, asynchronously. After release, command 8'h0F, amount=4, dir=1 -> 8'hF0.
6. Random amount/direction/data plus random out_ready backpressure, compared against a reference rotate model -> all results match, in order, none lost or duplicated.
